uart_rx: RTL and testbench
==========================

# uart_rx

Asynchronous serial receiver that turns a 1-start / DATA_BITS-data / 1-stop bit stream (LSB first, line idle high) on a single `rx` wire into parallel words. It is the receiving end of the serial bit stream our flip-flop and shift-register blocks produce. It sits at the chip pin, behind nothing but its own synchronizer, and feeds parallel consumers through a one-cycle `valid` strobe. Bit timing is derived from the system clock by a fixed divider; there is no oversampling majority vote.

## Interface
- `CLKS_PER_BIT`, default 16: clk cycles per serial bit. Must be even and >= 4.
- `DATA_BITS`, default 8: data bits per frame, range 5..9.
- `clk` in, 1 bit: single system clock, rising-edge.
- `rst` in, 1 bit: reset, asynchronous assert, active-low (0 = reset).
- `rx` in, 1 bit: serial line, asynchronous to `clk`, idle = 1.
- `data` out, DATA_BITS bits: last good word. Holds its value until the next good frame.
- `valid` out, 1 bit: one-cycle pulse, `data` is new.
- `frame_err` out, 1 bit: one-cycle pulse, stop bit sampled 0.
- `busy` out, 1 bit: high in every state except IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer to give `rx_s`. Both flops and `rx_prev` reset to 1.
- Reset values: `data`=0, `valid`=0, `frame_err`=0, `busy`=0, state=IDLE, cnt=0, bit_idx=0, shift register=0.
- The state machine has five states:
  - IDLE: if `rx_prev`=1 and `rx_s`=0 (falling edge), go to START with cnt=0. A line held low never triggers a frame.
  - START: when cnt==CLKS_PER_BIT/2-1, check `rx_s`. If `rx_s`=0, go to DATA with cnt=0 and bit_idx=0. If `rx_s`=1, treat it as a glitch and return to IDLE with no output pulse. Otherwise increment cnt.
  - DATA: when cnt==CLKS_PER_BIT-1, shift `rx_s` in at the MSB and shift right, so the first received bit lands in bit 0. Set cnt=0. If bit_idx==DATA_BITS-1, go to STOP; otherwise increment bit_idx.
  - STOP: when cnt==CLKS_PER_BIT-1, check `rx_s`. If `rx_s`=1, load `data` from the shift register, pulse `valid`, and go to IDLE. If `rx_s`=0, pulse `frame_err`, leave `data` unchanged, and go to BREAK.
  - BREAK: stay until `rx_s`=1, then go to IDLE. This suppresses the false start edge after a break or framing error.
- `valid` and `frame_err` never assert together and never last more than one cycle.
- The counter is $clog2(CLKS_PER_BIT) bits and bit_idx is $clog2(DATA_BITS) bits. Neither ever wraps past its terminal value.
- Reset asserted mid-frame aborts the frame immediately: no pulse, and `data` returns to 0.

## Timing
- Edge 1 is the first rising edge at which `rx`=0 is captured.
- Edge 2: `rx_s`=0. Edge 3: state changes to START.
- Start bit sampled at edge 3+CLKS_PER_BIT/2.
- Data bit k (k=0..DATA_BITS-1) sampled at edge 3+CLKS_PER_BIT/2+(k+1)*CLKS_PER_BIT.
- Stop bit sampled at edge N = 3+CLKS_PER_BIT/2+(DATA_BITS+1)*CLKS_PER_BIT. `valid`/`frame_err` are high for the cycle following edge N. With the defaults, N=155.
- The next frame's start edge is accepted from edge N+1 onward (back-to-back frames supported). The stop bit seen at mid-bit counts as idle.

## Structure
- `uart_pkg` holds the state encoding localparams (IDLE=0, START=1, DATA=2, STOP=3, BREAK=4) and the default CLKS_PER_BIT/DATA_BITS values. The matching future `uart_tx` shares the package.
- One sub-module, `sync_2ff`: 2-flop synchronizer with a parameterized reset value (1 here), using the same async active-low `rst`.

## Test plan
All scenarios use the defaults (CLKS_PER_BIT=16, DATA_BITS=8).
- Reset: hold `rst`=0 with `rx`=1 → all outputs 0 and `busy`=0. Release `rst`, hold `rx`=1 for 100 cycles → no pulse.
- Single frame 0xA5: drive the bits at 16 clk each → `valid` high for exactly one cycle at edge 155 relative to the start, `data`=0xA5, `frame_err`=0.
- Back-to-back frames 0x00 then 0xFF with no idle gap → two `valid` pulses 160 cycles apart, `data`=0x00 then 0xFF.
- Glitch: `rx` low for 3 cycles, then high → state returns to IDLE, `busy` drops, no pulse.
- Framing error: frame 0x3C with stop bit 0, then `rx` held low 50 cycles, then high → one `frame_err` pulse, `data` keeps its previous value, no new frame until `rx` returns high. A following 0x11 frame gives `valid` with `data`=0x11.
- Reset mid-frame: assert `rst` during data bit 4 → `busy`=0 and `data`=0 asynchronously. After release, a full 0x5A frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and default frame parameters shared by the UART blocks.
package uart_pkg;
  typedef logic [2:0] state_t;
  localparam state_t IDLE  = 3'd0;
  localparam state_t START = 3'd1;
  localparam state_t DATA  = 3'd2;
  localparam state_t STOP  = 3'd3;
  localparam state_t BREAK = 3'd4;
  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int DEF_DATA_BITS    = 8;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous input, with selectable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) {q, meta} <= {2{RST_VAL}};
    else      {q, meta} <= {meta, d};
  end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 1-start / DATA_BITS-data / 1-stop serial receiver, LSB first, mid-bit sampling.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEF_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [BW-1:0] bit_idx, bit_idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n, data_n;
  logic valid_n, frame_err_n, rx_s, rx_prev;
  sync_2ff #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst(rst), .d(rx), .q(rx_s));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      rx_prev   <= 1'b1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_idx_n;
      shreg     <= shreg_n;
      data      <= data_n;
      valid     <= valid_n;
      frame_err <= frame_err_n;
      rx_prev   <= rx_s;
    end
  end
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    bit_idx_n   = bit_idx;
    shreg_n     = shreg;
    data_n      = data;
    valid_n     = 1'b0;
    frame_err_n = 1'b0;
    case (state)
      IDLE: if (rx_prev && !rx_s) begin
        state_n = START;
        cnt_n   = '0;
      end
      START: if (cnt == HALF) begin
        state_n   = rx_s ? IDLE : DATA;
        cnt_n     = '0;
        bit_idx_n = '0;
      end else cnt_n = cnt + CW'(1);
      DATA: if (cnt == FULL) begin
        shreg_n   = {rx_s, shreg[DATA_BITS-1:1]};
        cnt_n     = '0;
        state_n   = (bit_idx == LAST) ? STOP : DATA;
        bit_idx_n = (bit_idx == LAST) ? bit_idx : bit_idx + BW'(1);
      end else cnt_n = cnt + CW'(1);
      STOP: if (cnt == FULL) begin
        cnt_n       = '0;
        state_n     = rx_s ? IDLE : BREAK;
        valid_n     = rx_s;
        frame_err_n = !rx_s;
        data_n      = rx_s ? shreg : data;
      end else cnt_n = cnt + CW'(1);
      BREAK: state_n = rx_s ? IDLE : BREAK;
      default: state_n = IDLE;
    endcase
  end
  always_comb busy = (state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scenario tasks plus randomized frames checked against a frame-timing model.
module tb_uart_rx;
  localparam int CPB = 16;
  localparam int DB  = 8;
  localparam int N   = 3 + CPB / 2 + (DB + 1) * CPB;
  localparam int K_VALID = 1;
  localparam int K_FERR  = 2;
  logic clk = 1'b0, rst = 1'b0, rx = 1'b1;
  logic [DB-1:0] data;
  logic valid, frame_err, busy;
  int cyc = 0, checks = 0, passed = 0, overlap = 0;
  int ev_t[$], ev_k[$];
  logic [DB-1:0] ev_d[$];
  logic [DB-1:0] last_good = '0;
  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk(clk), .rst(rst), .rx(rx), .data(data), .valid(valid), .frame_err(frame_err), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (valid || frame_err) begin
      ev_t.push_back(cyc);
      ev_k.push_back(valid ? K_VALID : K_FERR);
      ev_d.push_back(data);
    end
    if (valid && frame_err) overlap++;
  end
  task automatic clear_events();
    ev_t.delete(); ev_k.delete(); ev_d.delete();
  endtask
  task automatic drive_bit(input logic b, input int n);
    rx = b;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send_frame(input logic [DB-1:0] d, input logic stop, output int t0);
    t0 = cyc;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < DB; i++) drive_bit(d[i], CPB);
    drive_bit(stop, CPB);
  endtask
  task automatic test_reset();
    rst = 1'b0; rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", valid); else passed++;
    checks++; if (frame_err !== 1'b0) $display("FAIL reset_ferr got=%b exp=0", frame_err); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
    checks++; if (data !== '0) $display("FAIL reset_data got=%h exp=00", data); else passed++;
    rst = 1'b1;
    clear_events();
    repeat (100) @(posedge clk);
    #1;
    checks++; if (ev_t.size() !== 0) $display("FAIL idle_pulses got=%0d exp=0", ev_t.size()); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL idle_busy got=%b exp=0", busy); else passed++;
  endtask
  task automatic test_single();
    int t0;
    clear_events();
    send_frame(8'hA5, 1'b1, t0);
    last_good = 8'hA5;
    checks++; if (ev_t.size() !== 1) $display("FAIL single_count got=%0d exp=1", ev_t.size()); else passed++;
    checks++; if ((ev_t.size() > 0 ? ev_t[0] - t0 : -1) !== N) $display("FAIL single_time got=%0d exp=%0d", ev_t.size() > 0 ? ev_t[0] - t0 : -1, N); else passed++;
    checks++; if ((ev_k.size() > 0 ? ev_k[0] : 0) !== K_VALID) $display("FAIL single_kind got=%0d exp=%0d", ev_k.size() > 0 ? ev_k[0] : 0, K_VALID); else passed++;
    checks++; if (data !== 8'hA5) $display("FAIL single_data got=%h exp=a5", data); else passed++;
  endtask
  task automatic test_back_to_back();
    int t0, t1;
    clear_events();
    send_frame(8'h00, 1'b1, t0);
    send_frame(8'hFF, 1'b1, t1);
    last_good = 8'hFF;
    checks++; if (ev_t.size() !== 2) $display("FAIL b2b_count got=%0d exp=2", ev_t.size()); else passed++;
    checks++; if ((ev_t.size() > 1 ? ev_t[1] - ev_t[0] : -1) !== 160) $display("FAIL b2b_spacing got=%0d exp=160", ev_t.size() > 1 ? ev_t[1] - ev_t[0] : -1); else passed++;
    checks++; if ((ev_d.size() > 0 ? ev_d[0] : 8'hxx) !== 8'h00) $display("FAIL b2b_data0 got=%h exp=00", ev_d.size() > 0 ? ev_d[0] : 8'hxx); else passed++;
    checks++; if ((ev_d.size() > 1 ? ev_d[1] : 8'hxx) !== 8'hFF) $display("FAIL b2b_data1 got=%h exp=ff", ev_d.size() > 1 ? ev_d[1] : 8'hxx); else passed++;
  endtask
  task automatic test_glitch();
    clear_events();
    drive_bit(1'b0, 3);
    drive_bit(1'b1, 2);
    checks++; if (busy !== 1'b1) $display("FAIL glitch_busy_hi got=%b exp=1", busy); else passed++;
    drive_bit(1'b1, 20);
    checks++; if (busy !== 1'b0) $display("FAIL glitch_busy_lo got=%b exp=0", busy); else passed++;
    checks++; if (ev_t.size() !== 0) $display("FAIL glitch_pulses got=%0d exp=0", ev_t.size()); else passed++;
  endtask
  task automatic test_framing();
    int t0, t1;
    clear_events();
    send_frame(8'h3C, 1'b0, t0);
    drive_bit(1'b0, 50);
    checks++; if (ev_t.size() !== 1) $display("FAIL ferr_count got=%0d exp=1", ev_t.size()); else passed++;
    checks++; if ((ev_k.size() > 0 ? ev_k[0] : 0) !== K_FERR) $display("FAIL ferr_kind got=%0d exp=%0d", ev_k.size() > 0 ? ev_k[0] : 0, K_FERR); else passed++;
    checks++; if ((ev_t.size() > 0 ? ev_t[0] - t0 : -1) !== N) $display("FAIL ferr_time got=%0d exp=%0d", ev_t.size() > 0 ? ev_t[0] - t0 : -1, N); else passed++;
    checks++; if (data !== last_good) $display("FAIL ferr_data got=%h exp=%h", data, last_good); else passed++;
    checks++; if (busy !== 1'b1) $display("FAIL break_busy got=%b exp=1", busy); else passed++;
    drive_bit(1'b1, 5);
    checks++; if (busy !== 1'b0) $display("FAIL break_exit got=%b exp=0", busy); else passed++;
    clear_events();
    send_frame(8'h11, 1'b1, t1);
    last_good = 8'h11;
    checks++; if ((ev_k.size() == 1 ? ev_k[0] : 0) !== K_VALID) $display("FAIL after_ferr_kind got=%0d exp=%0d", ev_k.size() == 1 ? ev_k[0] : 0, K_VALID); else passed++;
    checks++; if (data !== 8'h11) $display("FAIL after_ferr_data got=%h exp=11", data); else passed++;
  endtask
  task automatic test_reset_mid();
    logic [DB-1:0] d = 8'h5A;
    int t0;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_bit(d[i], CPB);
    rx = d[4];
    repeat (8) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL midrst_busy got=%b exp=0", busy); else passed++;
    checks++; if (data !== '0) $display("FAIL midrst_data got=%h exp=00", data); else passed++;
    checks++; if (valid !== 1'b0) $display("FAIL midrst_valid got=%b exp=0", valid); else passed++;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    last_good = '0;
    drive_bit(1'b1, 5);
    clear_events();
    send_frame(d, 1'b1, t0);
    last_good = d;
    checks++; if (ev_t.size() !== 1) $display("FAIL midrst_count got=%0d exp=1", ev_t.size()); else passed++;
    checks++; if (data !== 8'h5A) $display("FAIL midrst_frame got=%h exp=5a", data); else passed++;
  endtask
  task automatic test_random();
    int et[$], ek[$];
    logic [DB-1:0] ed[$];
    int t0, n;
    logic [DB-1:0] d;
    logic stop;
    clear_events();
    for (int f = 0; f < 24; f++) begin
      d = DB'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      send_frame(d, stop, t0);
      et.push_back(t0 + N);
      ek.push_back(stop ? K_VALID : K_FERR);
      if (stop) last_good = d;
      ed.push_back(last_good);
      drive_bit(1'b1, stop ? $urandom_range(0, 6) : $urandom_range(4, 20));
    end
    drive_bit(1'b1, 5);
    checks++; if (ev_t.size() !== et.size()) $display("FAIL rand_count got=%0d exp=%0d", ev_t.size(), et.size()); else passed++;
    n = ev_t.size() < et.size() ? ev_t.size() : et.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (ev_t[i] !== et[i] || ev_k[i] !== ek[i] || ev_d[i] !== ed[i])
        $display("FAIL rand_frame%0d got t=%0d k=%0d d=%h exp t=%0d k=%0d d=%h", i, ev_t[i], ev_k[i], ev_d[i], et[i], ek[i], ed[i]);
      else passed++;
    end
    checks++; if (overlap !== 0) $display("FAIL pulse_overlap got=%0d exp=0", overlap); else passed++;
  endtask
  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
